// File: rtl/loop_sequencer.sv
// Loop sequencer: runs REPEAT / WHILE / DO_WHILE / FOREVER loops around an external body.
// Define LOOP_SEQ_WATCHDOG_EN to cap non-REPEAT loops at WDOG_LIMIT iterations.
module loop_sequencer #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             cond,
  input  logic             body_done,
  input  logic             brk,
  input  logic             cont,
  output logic             body_start,
  output logic [CNT_W-1:0] iter_idx,
  output logic             busy,
  output logic             done,
  output logic             broken,
  output logic             timeout
);

  typedef enum logic [2:0] {StIdle, StCheck, StBody, StWait, StFin} state_e;

  localparam logic [1:0] ModeRepeat  = 2'd0;
  localparam logic [1:0] ModeWhile   = 2'd1;
  localparam logic [1:0] ModeDoWhile = 2'd2;
  localparam logic [1:0] ModeForever = 2'd3;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             broken_q, broken_d;
  logic             check_go;
  logic             wdog_hit;

  always_comb begin
    check_go = 1'b0;
    unique case (mode_q)
      ModeRepeat:  check_go = (iter_q < count_q);
      ModeWhile:   check_go = cond;
      ModeDoWhile: check_go = (iter_q == '0) || cond;
      ModeForever: check_go = 1'b1;
    endcase
  end

`ifdef LOOP_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WdogIter = CNT_W'(WDOG_LIMIT);

  logic timeout_q, timeout_d;

  // Watchdog outranks cond for every loop kind whose length is not bounded by count.
  assign wdog_hit = (mode_q != ModeRepeat) && (iter_q == WdogIter);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if (state_q == StIdle && start) begin
      timeout_d = 1'b0;
    end else if (state_q == StCheck && wdog_hit) begin
      timeout_d = 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign wdog_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    iter_d   = iter_q;
    broken_d = broken_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d   = mode;
          count_d  = count;
          iter_d   = '0;
          broken_d = 1'b0;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        state_d = (check_go && !wdog_hit) ? StBody : StFin;
      end
      StBody: begin
        state_d = StWait;
      end
      StWait: begin
        // Break wins over a completion reported in the same cycle.
        if (brk) begin
          broken_d = 1'b1;
          state_d  = StFin;
        end else if (cont || body_done) begin
          iter_d  = iter_q + CNT_W'(1);
          state_d = StCheck;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mode_q   <= ModeRepeat;
      count_q  <= '0;
      iter_q   <= '0;
      broken_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      iter_q   <= iter_d;
      broken_q <= broken_d;
    end
  end

  assign body_start = (state_q == StBody);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin);
  assign iter_idx   = iter_q;
  assign broken     = broken_q;

endmodule

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer: per-cycle waveform compared against a timeline model.
module tb_loop_sequencer;

  localparam int CW     = 4;
  localparam int WD     = 8;
  localparam int MaxIt  = 64;
  localparam int MaxCyc = 512;
`ifdef LOOP_SEQ_WATCHDOG_EN
  localparam bit WdogOn = 1'b1;
`else
  localparam bit WdogOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, cond, body_done, brk, cont;
  logic [1:0]    mode;
  logic [CW-1:0] count;
  logic          body_start, busy, done, broken, timeout;
  logic [CW-1:0] iter_idx;

  loop_sequencer #(
    .CNT_W     (CW),
    .WDOG_LIMIT(WD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .count     (count),
    .cond      (cond),
    .body_done (body_done),
    .brk       (brk),
    .cont      (cont),
    .body_start(body_start),
    .iter_idx  (iter_idx),
    .busy      (busy),
    .done      (done),
    .broken    (broken),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-iteration plan: cond seen at that check, wait cycles before reply, reply kind
  // (0 body_done, 1 cont, 2 brk, 3 brk+body_done, 4 brk+cont).
  int plan_cond[MaxIt];
  int plan_delay[MaxIt];
  int plan_act[MaxIt];
  int wait_cyc[MaxIt];

  bit exp_bs[MaxCyc];
  int exp_it[MaxCyc];
  bit drv_cond[MaxCyc], drv_bd[MaxCyc], drv_brk[MaxCyc], drv_cont[MaxCyc];
  int fin_cyc, fin_it;
  bit exp_brk, exp_to;
  bit last_brk, last_to;
  int last_it;

  function automatic void plan_default();
    for (int i = 0; i < MaxIt; i++) begin
      plan_cond[i]  = (i < 30) ? 1 : 0;
      plan_delay[i] = 0;
      plan_act[i]   = (i == 30) ? 2 : 0;
    end
  endfunction

  function automatic void plan_random();
    for (int i = 0; i < MaxIt; i++) begin
      plan_cond[i]  = (i < 30 && $urandom_range(0, 4) != 0) ? 1 : 0;
      plan_delay[i] = $urandom_range(0, 3);
      if (i >= 30 || $urandom_range(0, 11) == 0) plan_act[i] = $urandom_range(2, 4);
      else plan_act[i] = $urandom_range(0, 1);
    end
  endfunction

  // Cycle 0 is the cycle after the edge that sampled start.
  function automatic void build(input int md, input int cnt);
    int t, it, itm, w;
    bit go, stop;
    for (int c = 0; c < MaxCyc; c++) begin
      exp_bs[c]   = 1'b0;
      exp_it[c]   = 0;
      drv_cond[c] = 1'($urandom_range(0, 1));
      drv_bd[c]   = 1'($urandom_range(0, 1));
      drv_brk[c]  = 1'($urandom_range(0, 1));
      drv_cont[c] = 1'($urandom_range(0, 1));
    end
    t = 0; it = 0; stop = 1'b0; exp_brk = 1'b0; exp_to = 1'b0; fin_cyc = 0;
    while (!stop) begin
      itm = it % (1 << CW);
      exp_it[t]   = itm;
      drv_cond[t] = (plan_cond[it] != 0);
      go = 1'b0;
      if (WdogOn && md != 0 && itm == WD) exp_to = 1'b1;
      else begin
        case (md)
          0:       go = (itm < cnt);
          1:       go = (plan_cond[it] != 0);
          2:       go = (itm == 0) || (plan_cond[it] != 0);
          default: go = 1'b1;
        endcase
      end
      if (!go) begin
        fin_cyc = t + 1;
        stop    = 1'b1;
      end else begin
        exp_bs[t+1] = 1'b1;
        exp_it[t+1] = itm;
        wait_cyc[it] = t + 2;
        for (int d = 0; d <= plan_delay[it]; d++) begin
          w = t + 2 + d;
          exp_it[w] = itm;
          drv_bd[w] = 1'b0; drv_brk[w] = 1'b0; drv_cont[w] = 1'b0;
        end
        w = t + 2 + plan_delay[it];
        case (plan_act[it])
          0:       drv_bd[w] = 1'b1;
          1:       drv_cont[w] = 1'b1;
          2:       drv_brk[w] = 1'b1;
          3:       begin drv_brk[w] = 1'b1; drv_bd[w] = 1'b1; end
          default: begin drv_brk[w] = 1'b1; drv_cont[w] = 1'b1; end
        endcase
        if (plan_act[it] >= 2) begin
          fin_cyc = w + 1;
          exp_brk = 1'b1;
          stop    = 1'b1;
        end else begin
          it++;
          t = w + 1;
        end
      end
    end
    fin_it = it % (1 << CW);
    exp_it[fin_cyc] = fin_it;
  endfunction

  function automatic logic [31:0] exp_vec(input int t);
    logic bs, dn, bz, br, to;
    logic [CW-1:0] itv;
    if (t <= fin_cyc) begin
      bs = exp_bs[t]; dn = (t == fin_cyc); bz = 1'b1;
      br = (t == fin_cyc) && exp_brk; to = (t == fin_cyc) && exp_to;
      itv = CW'(exp_it[t]);
    end else begin
      bs = 1'b0; dn = 1'b0; bz = 1'b0; br = exp_brk; to = exp_to; itv = CW'(fin_it);
    end
    return {23'd0, bs, dn, bz, br, to, itv};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {23'd0, body_start, done, busy, broken, timeout, iter_idx};
  endfunction

  function automatic logic [31:0] idle_vec();
    return {23'd0, 1'b0, 1'b0, 1'b0, last_brk, last_to, CW'(last_it)};
  endfunction

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 check("rst_async", dut_vec(), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold", dut_vec(), 32'd0);
    end
    rst_n = 1'b1;
    last_brk = 1'b0; last_to = 1'b0; last_it = 0;
  endtask

  // Entered and left just after a falling edge with the DUT idle.
  task automatic run_loop(input int md, input int cnt, input int gap, input int abort_it);
    int abort_cyc;
    build(md, cnt);
    abort_cyc = (abort_it >= 0) ? wait_cyc[abort_it] : -1;
    for (int g = 0; g < gap; g++) begin
      start = 1'b0;
      brk = 1'($urandom_range(0, 1)); cont = 1'($urandom_range(0, 1));
      body_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_gap", dut_vec(), idle_vec());
    end
    start = 1'b1; mode = 2'(md); count = CW'(cnt);
    @(posedge clk);
    #1;
    for (int t = 0; t <= fin_cyc + 1; t++) begin
      start     = (t <= fin_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
      mode      = 2'($urandom);
      count     = CW'($urandom);
      cond      = drv_cond[t];
      body_done = drv_bd[t];
      brk       = drv_brk[t];
      cont      = drv_cont[t];
      @(negedge clk);
      check($sformatf("run m%0d c%0d t%0d", md, cnt, t), dut_vec(), exp_vec(t));
      if (t == abort_cyc) begin
        start = 1'b0; brk = 1'b0; cont = 1'b0; body_done = 1'b0;
        do_reset();
        return;
      end
      if (t <= fin_cyc) begin
        @(posedge clk);
        #1;
      end
    end
    last_brk = exp_brk; last_to = exp_to; last_it = fin_it;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; count = '0;
    cond = 1'b0; body_done = 1'b0; brk = 1'b0; cont = 1'b0;
    last_brk = 1'b0; last_to = 1'b0; last_it = 0;
    @(negedge clk);
    check("reset_state", dut_vec(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", dut_vec(), 32'd0);

    plan_default();                       run_loop(0, 3, 0, -1);   // REPEAT 3
    plan_default();                       run_loop(0, 0, 1, -1);   // REPEAT 0
    plan_default(); plan_cond[0] = 0;     run_loop(1, 0, 0, -1);   // WHILE, cond low
    plan_default();
    for (int i = 0; i < MaxIt; i++) plan_cond[i] = 0;
    run_loop(2, 0, 0, -1);                                         // DO_WHILE, cond low
    plan_default(); plan_act[5] = 3;      run_loop(3, 0, 0, -1);   // FOREVER, brk+done at 5
    plan_default(); plan_act[1] = 1;      run_loop(0, 4, 0, -1);   // REPEAT 4, cont at 1
    plan_default(); plan_delay[2] = 2;    run_loop(0, 5, 0, 2);    // reset during WAIT of 2
    plan_default();                       run_loop(0, 2, 0, -1);   // first start after reset
    plan_default(); plan_act[19] = 2;     run_loop(3, 0, 0, -1);   // FOREVER: wrap or watchdog
    plan_default(); plan_delay[3] = 3;    run_loop(0, 15, 2, -1);  // REPEAT max count

    for (int r = 0; r < 40; r++) begin
      plan_random();
      run_loop($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 2), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
